// File: rtl/pc_unit.sv
// 6502-style program counter: PCL/PCH with inter-byte carry, vector loads, relative
// branches with a page-cross fix-up cycle, and per-byte tri-state bus drivers.
module pc_unit #(
    parameter int unsigned        LW       = 8,
    parameter int unsigned        HW       = 8,
    parameter logic [LW+HW-1:0]   RESET_PC = 16'h0000,
    parameter logic [LW+HW-1:0]   RST_VEC  = 16'hFFFC,
    parameter logic [LW+HW-1:0]   NMI_VEC  = 16'hFFFA,
    parameter logic [LW+HW-1:0]   IRQ_VEC  = 16'hFFFE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [LW-1:0] adlin,
    input  logic [HW-1:0] adhin,
    input  logic          adlwa,
    input  logic          adhwa,
    input  logic          inc,
    input  logic          brtake,
    input  logic [LW-1:0] offset,
    input  logic          setreset,
    input  logic          setnmi,
    input  logic          setirq,
    input  logic          adloa,
    input  logic          adhoa,
    input  logic          dbloa,
    input  logic          dbhoa,
    output logic [LW-1:0] adlout,
    output logic [HW-1:0] adhout,
    output logic [LW-1:0] dblout,
    output logic [HW-1:0] dbhout,
    output logic          pagecross,
    output logic          busy
);
    localparam int unsigned PcW = LW + HW;

    typedef enum logic {StIdle, StBrFix} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] pcl_q, pcl_d;
    logic [HW-1:0] pch_q, pch_d;
    logic          dir_q, dir_d;
    logic          pagecross_q, pagecross_d;
    logic          busy_q, busy_d;

    logic [LW:0]   br_sum;
    logic          br_cross;
    logic [PcW-1:0] pc_inc;

    always_comb begin
        br_sum   = {1'b0, pcl_q} + {1'b0, offset};
        // Positive offset crosses on carry-out, negative offset crosses on no carry (borrow).
        br_cross = offset[LW-1] ^ br_sum[LW];
        pc_inc   = {pch_q, pcl_q} + PcW'(1);

        pcl_d   = pcl_q;
        pch_d   = pch_q;
        state_d = state_q;
        dir_d   = dir_q;

        if (setreset) begin
            {pch_d, pcl_d} = RST_VEC;
            state_d        = StIdle;
        end else if (setnmi) begin
            {pch_d, pcl_d} = NMI_VEC;
            state_d        = StIdle;
        end else if (setirq) begin
            {pch_d, pcl_d} = IRQ_VEC;
            state_d        = StIdle;
        end else if (adlwa || adhwa) begin
            if (adlwa) pcl_d = adlin;
            if (adhwa) pch_d = adhin;
            state_d = StIdle;
        end else if (state_q == StBrFix) begin
            pch_d   = dir_q ? pch_q - HW'(1) : pch_q + HW'(1);
            state_d = StIdle;
        end else if (brtake) begin
            pcl_d = br_sum[LW-1:0];
            if (br_cross) begin
                state_d = StBrFix;
                dir_d   = offset[LW-1];
            end
        end else if (inc) begin
            {pch_d, pcl_d} = pc_inc;
        end

        pagecross_d = (state_d == StBrFix);
        busy_d      = (state_d == StBrFix);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {pch_q, pcl_q} <= RESET_PC;
            state_q        <= StIdle;
            dir_q          <= 1'b0;
            pagecross_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            pcl_q       <= pcl_d;
            pch_q       <= pch_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            pagecross_q <= pagecross_d;
            busy_q      <= busy_d;
        end
    end

    assign adlout    = adloa ? pcl_q : {LW{1'bz}};
    assign adhout    = adhoa ? pch_q : {HW{1'bz}};
    assign dblout    = dbloa ? pcl_q : {LW{1'bz}};
    assign dbhout    = dbhoa ? pch_q : {HW{1'bz}};
    assign pagecross = pagecross_q;
    assign busy      = busy_q;

endmodule
